// File: rtl/rr_sel_gen.sv
// rr_sel_gen: round-robin arbiter over 8 requests producing a registered 3-bit decoder select plus valid.
// Define RR_SEL_TIMEOUT_EN to add a HOLD_MAX-cycle grant timeout and the tmo pulse output.
module rr_sel_gen #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic       valid,
    output logic       busy
`ifdef RR_SEL_TIMEOUT_EN
   ,output logic       tmo
`endif
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state, state_nx;
    logic [2:0] ptr, pick;
    logic       to_hit, rel;
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("HOLD_MAX must be in 1..255");
    end
    // Descending scan so the channel closest to ptr wins.
    always_comb begin
        pick = ptr;
        for (int i = 7; i >= 0; i--)
            if (req[3'(ptr + 3'(i))]) pick = 3'(ptr + 3'(i));
    end
    assign rel      = done | ~req[sel] | to_hit;
    assign state_nx = (state == IDLE) ? ((|req) ? GRANT : IDLE) : (rel ? IDLE : GRANT);
    assign busy     = valid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 3'd0;
            valid <= 1'b0;
            ptr   <= 3'd0;
        end else begin
            state <= state_nx;
            valid <= (state_nx == GRANT);
            if (state == IDLE && |req) sel <= pick;
            if (state == GRANT && rel) ptr <= sel + 3'd1;
        end
    end
`ifdef RR_SEL_TIMEOUT_EN
    logic [7:0] cnt;
    assign to_hit = (state == GRANT) && (cnt == 8'(HOLD_MAX - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
            tmo <= 1'b0;
        end else begin
            cnt <= (state == GRANT && state_nx == GRANT) ? cnt + 8'd1 : 8'd0;
            tmo <= to_hit & ~done & req[sel];
        end
    end
`else
    assign to_hit = 1'b0;
`endif
endmodule

// File: tb/tb_rr_sel_gen.sv
// tb_rr_sel_gen: scoreboard bench for rr_sel_gen; covers the timeout path when RR_SEL_TIMEOUT_EN is defined.
module tb_rr_sel_gen;
    localparam int HM = 4;
`ifdef RR_SEL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [2:0] sel;
    logic       valid, busy, tmo_o;
    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];
    bit         m_valid, m_tmo;
    int         m_sel, m_ptr, m_cnt;
    int         vcnt;

    always #5 clk = ~clk;

    rr_sel_gen #(.HOLD_MAX(HM)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .sel(sel), .valid(valid), .busy(busy)
`ifdef RR_SEL_TIMEOUT_EN
       ,.tmo(tmo_o)
`endif
    );
`ifndef RR_SEL_TIMEOUT_EN
    assign tmo_o = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_tmo = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    endtask

    // Reference behaviour for one clock edge given the inputs held during the preceding cycle.
    task automatic model_step(input logic [7:0] r, input logic d);
        bit hit;
        if (!m_valid) begin
            m_tmo = 0;
            if (r != 8'h00) begin
                for (int i = 7; i >= 0; i--)
                    if (r[(m_ptr + i) % 8]) m_sel = (m_ptr + i) % 8;
                m_valid = 1;
                m_cnt = 0;
            end
        end else begin
            hit = TO_EN && (m_cnt == HM - 1);
            if (d || !r[m_sel] || hit) begin
                m_tmo = hit && !d && r[m_sel];
                m_valid = 0;
                m_ptr = (m_sel + 1) % 8;
            end else begin
                m_tmo = 0;
                m_cnt++;
            end
        end
    endtask

    task automatic step(input logic [7:0] r, input logic d);
        logic [4:0] e;
        req = r;
        done = d;
        model_step(r, d);
        exp_q.push_back({m_tmo, m_valid, 3'(m_sel)});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("cycle", {27'd0, tmo_o, valid, sel}, {27'd0, e});
        check("busy", {31'd0, busy}, {31'd0, e[3]});
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = 8'h00; done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {27'd0, tmo_o, busy, valid, sel}, 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        apply_reset();
        step(8'h00, 1'b0);
        step(8'h20, 1'b0);
        check("single_sel", {29'd0, sel}, 32'd5);
        step(8'h20, 1'b1);
        step(8'h41, 1'b0);
        check("ptr_after5", {29'd0, sel}, 32'd6);
        step(8'h41, 1'b1);
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 1'b0);
            check("rr_seq", {29'd0, sel}, 32'(i % 8));
            step(8'hFF, 1'b1);
            check("rr_bubble", {31'd0, valid}, 32'd0);
        end
        step(8'h80, 1'b0);
        check("wrap_7", {29'd0, sel}, 32'd7);
        step(8'h80, 1'b1);
        step(8'h81, 1'b0);
        check("wrap_0", {29'd0, sel}, 32'd0);
        step(8'h81, 1'b1);
        step(8'h81, 1'b0);
        check("wrap_7b", {29'd0, sel}, 32'd7);
        step(8'h81, 1'b1);
        step(8'h08, 1'b0);
        step(8'h00, 1'b0);
        check("drop_tmo", {31'd0, tmo_o}, 32'd0);
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        step(8'h02, 1'b0);
        step(8'h03, 1'b0);
        check("no_preempt", {29'd0, sel}, 32'd1);
        step(8'h03, 1'b1);
        step(8'h03, 1'b0);
        step(8'h03, 1'b1);
        vcnt = 0;
        step(8'h04, 1'b0);
        for (int i = 0; i < 10 && valid; i++) begin
            vcnt++;
            step(8'h04, 1'b0);
        end
        check("hold_len", 32'(vcnt), TO_EN ? 32'(HM) : 32'd10);
        check("tmo_pulse", {31'd0, tmo_o}, {31'd0, TO_EN});
        step(8'h04, 1'b0);
        check("regrant", {28'd0, valid, sel}, 32'hA);
        for (int i = 0; i < HM - 1; i++) step(8'h04, 1'b0);
        step(8'h04, 1'b1);
        step(8'h40, 1'b0);
        check("mid_sel", {28'd0, valid, sel}, 32'hE);
        rst = 1'b1;
        #1;
        check("async_rst", {28'd0, valid, sel}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(8'h41, 1'b0);
        check("post_rst", {28'd0, valid, sel}, 32'h8);
        step(8'h41, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rr_sel_gen.md
Name: rr_sel_gen

Overview:
- Sequential source for the 3-to-8 decoder select input.
- Arbitrates 8 request lines round-robin and emits a registered 3-bit channel index plus a valid flag.
- Holds each grant until the grantee signals done, drops its request, or (optionally) times out.
- Output sel connects directly to the decoder's 3-bit input. The decoder's one-hot output is qualified with valid downstream.

Parameters:
- HOLD_MAX, 4, maximum GRANT cycles before forced release. Range 1..255. Used only when RR_SEL_TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req  input  8  per-channel request, level-sensitive; bit k = channel k
- done  input  1  grantee finished; sampled only in GRANT
- sel  output  3  granted channel index, registered
- valid  output  1  sel is a live grant, registered
- busy  output  1  high in GRANT state (equals valid)
- tmo  output  1  one-cycle timeout pulse; present only with RR_SEL_TIMEOUT_EN

Behaviour:
- Reset (async, rst=1): state=IDLE, sel=3'd0, valid=0, busy=0, ptr=3'd0, hold counter=0, tmo=0. Reset overrides everything, including mid-grant.
- Internal ptr (3 bits) is the highest-priority channel for the next arbitration.
- IDLE state:
  - If req==0, stay in IDLE with valid=0. sel keeps its last value.
  - Else pick the first k with req[k]=1, scanning ptr, ptr+1, … mod 8 (wraps from 7 to 0).
  - Next edge: sel<=k, valid<=1, state<=GRANT, counter<=0.
- Latency: a req sampled at edge n gives valid=1 after edge n. It is visible in the cycle after the sampling edge.
- GRANT state:
  - sel and valid stay stable.
  - Release condition is: done=1, OR req[sel]=0, OR a timeout (see Optional Feature).
  - On release, the next edge sets valid<=0, state<=IDLE, ptr<=sel+1 mod 8 (7 wraps to 0).
- Bubble: at least one IDLE cycle with valid=0 separates consecutive grants. Back-to-back grants are therefore every 2 cycles minimum.
- Simultaneous release causes (done with timeout, or done with req drop) produce a single release. tmo fires only when done=0 and req[sel]=1.
- done asserted while in IDLE is ignored.
- New requests arriving during GRANT do not preempt the grant. They are considered at the next IDLE cycle.
- Fairness: with all 8 requests held high and done pulsed each grant, grants go 0,1,…,7,0,…
- Reset mid-GRANT: valid drops asynchronously, ptr returns to 0, and the next grant goes to the lowest requesting channel.

Optional Feature:
- Macro: RR_SEL_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter increments each GRANT cycle.
  - When the counter reaches HOLD_MAX-1 with no other release condition, the grant is released at that edge.
  - tmo pulses high for the one cycle the state is IDLE after that release.
  - A grant therefore lasts at most HOLD_MAX cycles.
- Not defined:
  - No counter and no tmo port.
  - A grant lasts until done or until req[sel] drops. It may hold indefinitely.

Test Plan:
- Reset then one request: rst=1 for 2 cycles, then release with req=8'h00 → sel=0, valid=0. Then set req=8'h20 → after 1 edge sel=5, valid=1. Pulse done → next edge valid=0, and ptr=6 internally.
- Round-robin wrap: req=8'hFF, pulse done in every GRANT cycle → sel sequence 0,1,2,3,4,5,6,7,0, with valid=0 bubbles between grants.
- Priority after wrap: grant sel=7, then release with req=8'h81 → next grant sel=0; after that release, next grant sel=7.
- Request drop: grant ch3 (req=8'h08), then deassert req[3] with done=0 → valid=0 next edge. tmo stays 0.
- Timeout (macro on, HOLD_MAX=4): req=8'h04 held, done=0 → valid high exactly 4 cycles, then tmo=1 for 1 cycle. Regrant ch2 after the bubble.
- Reset mid-grant: while sel=6 and valid=1, assert rst → valid=0 immediately. Deassert rst with req=8'h41 → sel=0.
